// File: rtl/int_issue_unit.sv
// Integer issue/execute stage: takes one ready op from the reservation station,
// executes it (single-cycle ALU or multi-cycle MUL) and broadcasts the result on the CDB.
module int_issue_unit #(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 6,
  parameter int OP_W       = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issueque_ready,
  input  logic [DATA_W-1:0] issueque_rs1_data,
  input  logic [DATA_W-1:0] issueque_rs2_data,
  input  logic [TAG_W-1:0]  issueque_rd_tag,
  input  logic [OP_W-1:0]   issueque_opcode,
  output logic              issueblk_done,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(10);

  typedef enum logic [1:0] {IDLE, MUL, BCAST} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] op_a, op_b, result, alu_result;
  logic [TAG_W-1:0]  tag;
  logic [4:0]        shamt;
  logic              accept, is_mul, mul_finish;

  assign shamt         = issueque_rs2_data[4:0];
  assign is_mul        = (issueque_opcode == OP_MUL);
  assign issueblk_done = accept;

  // Single-cycle result; MUL only takes this path when it needs no extra cycles
  always_comb begin
    alu_result = '0;
    case (int'(issueque_opcode))
      0:  alu_result = issueque_rs1_data + issueque_rs2_data;
      1:  alu_result = issueque_rs1_data - issueque_rs2_data;
      2:  alu_result = issueque_rs1_data & issueque_rs2_data;
      3:  alu_result = issueque_rs1_data | issueque_rs2_data;
      4:  alu_result = issueque_rs1_data ^ issueque_rs2_data;
      5:  alu_result = issueque_rs1_data << shamt;
      6:  alu_result = issueque_rs1_data >> shamt;
      7:  alu_result = $signed(issueque_rs1_data) >>> shamt;
      8:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(issueque_rs1_data) < $signed(issueque_rs2_data))};
      9:  alu_result = {{(DATA_W-1){1'b0}}, (issueque_rs1_data < issueque_rs2_data)};
      10: alu_result = (MUL_CYCLES == 1) ? issueque_rs1_data * issueque_rs2_data : '0;
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Counter is loaded with MUL_CYCLES-1; the product is ready when it is about to reach 0
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mul_finish = 1'b0;
    cdb_req    = 1'b0;
    cdb_valid  = 1'b0;
    cdb_tag    = '0;
    cdb_data   = '0;
    case (state)
      IDLE: accept = issueque_ready;
      MUL: begin
        mul_finish = (count == CNT_W'(1));
        if (mul_finish) state_next = BCAST;
      end
      BCAST: begin
        cdb_req   = 1'b1;
        cdb_valid = cdb_grant;
        if (cdb_grant) begin
          cdb_tag    = tag;
          cdb_data   = result;
          accept     = issueque_ready;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    accept = accept & reset;
    if (accept) state_next = (is_mul && MUL_CYCLES > 1) ? MUL : BCAST;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      tag    <= '0;
      result <= '0;
    end else if (accept) begin
      op_a   <= issueque_rs1_data;
      op_b   <= issueque_rs2_data;
      tag    <= issueque_rd_tag;
      result <= alu_result;
      count  <= CNT_W'(MUL_CYCLES - 1);
    end else if (state == MUL) begin
      count <= count - CNT_W'(1);
      if (mul_finish) result <= op_a * op_b;
    end
  end

endmodule
